// File: rtl/status_readback.sv
// -----------------------------------------------------------------------------
// status_readback
//
// Read-direction partner to the GPIO-bus configuration write path. Snapshots a
// wide status word from fabric logic and returns it to the PS one byte per
// handshake, most significant byte first. The PS drives an address and a read
// strobe on gpio_in; the block answers with data and an acknowledge on
// gpio_out using a four-phase handshake (r_clk up -> ack up -> r_clk down ->
// ack down). One instance per readable status register, selected by my_addr.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-low reset
//   gpio_in   [15:0] address, [24] w_clk (unused here), [25] r_clk read
//             strobe, [26] rewind (restart at the MS byte)
//   reg_in    live status value, num_words bytes wide
//   gpio_out  [7:0] data, [8] ack, [9] last, [15:10] byte index, [31:16] zero
//
// Build option:
//   STATUS_READBACK_SYNC_EN  when defined, r_clk and rewind pass through
//                            2-flop synchronizers (read and release latency
//                            become 3 edges). The address is used raw because
//                            the PS holds it stable around the strobe.
// -----------------------------------------------------------------------------
module status_readback #(
    parameter int                    word_width = 8,
    parameter int                    num_words  = 4,
    parameter int                    addr_width = 16,
    parameter logic [addr_width-1:0] my_addr    = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     gpio_in,
    input  logic [num_words*word_width-1:0] reg_in,
    output logic [31:0]                     gpio_out
);

    // The index field is 6 bits wide, enough for up to 64 words.
    localparam int                   idx_width = 6;
    localparam logic [idx_width-1:0] last_idx  = idx_width'(num_words - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [idx_width-1:0]            idx;       // next byte to be returned
    logic [idx_width-1:0]            out_idx;   // index of the byte on gpio_out
    logic [num_words*word_width-1:0] snapshot;
    logic [num_words*word_width-1:0] byte_src;
    logic [word_width-1:0]           byte_sel;
    logic [word_width-1:0]           data_q;
    logic                            ack_q;
    logic                            last_q;

    logic match;
    logic r_clk;
    logic rewind;
    logic do_rewind;
    logic read_start;
    logic read_done;

    // w_clk, the reserved top bits and the address bits above addr_width
    // belong to other blocks on the shared bus.
    logic unused_bits;
    assign unused_bits = ^{gpio_in[31:27], gpio_in[24:addr_width]};

    // ------------------------------------------------------------------
    // Strobe conditioning
    // ------------------------------------------------------------------
`ifdef STATUS_READBACK_SYNC_EN
    logic [1:0] r_clk_sync;
    logic [1:0] rewind_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync  <= '0;
            rewind_sync <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], gpio_in[25]};
            rewind_sync <= {rewind_sync[0], gpio_in[26]};
        end
    end

    assign r_clk  = r_clk_sync[1];
    assign rewind = rewind_sync[1];
`else
    assign r_clk  = gpio_in[25];
    assign rewind = gpio_in[26];
`endif

    assign match = (gpio_in[addr_width-1:0] == my_addr);

    // Rewind wins over a simultaneous strobe; both only act in IDLE.
    assign do_rewind  = (state == IDLE) && match && rewind;
    assign read_start = (state == IDLE) && match && r_clk && !rewind;
    // Only the strobe dropping ends a cycle; the address is ignored in ACK.
    assign read_done  = (state == ACK) && !r_clk;

    // ------------------------------------------------------------------
    // Byte selection: idx 0 reads straight from reg_in so the first byte
    // matches the value being captured into snapshot on the same edge.
    // ------------------------------------------------------------------
    // NOTE: every signal driven from always_comb gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    always_comb begin
        byte_src = (idx == '0) ? reg_in : snapshot;
        byte_sel = '0;
        for (int i = 0; i < num_words; i++) begin
            if (idx == idx_width'(i)) begin
                byte_sel = byte_src[(num_words-1-i)*word_width +: word_width];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (read_start) state_next = ACK;
            ACK:  if (read_done)  state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers (index, snapshot, registered output fields)
    // ------------------------------------------------------------------
    // NOTE: the snapshot register is reset as well, so a read after reset
    // can never expose stale data even though idx 0 always recaptures it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            out_idx  <= '0;
            snapshot <= '0;
            data_q   <= '0;
            ack_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            if (do_rewind) begin
                idx <= '0;
            end else if (read_start) begin
                if (idx == '0) begin
                    snapshot <= reg_in;
                end
                data_q  <= byte_sel;
                ack_q   <= 1'b1;
                last_q  <= (idx == last_idx);
                out_idx <= idx;
            end else if (read_done) begin
                // Wrapping to 0 makes the next read take a fresh snapshot.
                ack_q <= 1'b0;
                idx   <= (idx == last_idx) ? '0 : idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: output assembly. Data, last and index stay put after ack falls.
    // ------------------------------------------------------------------
    always_comb begin
        gpio_out = {16'h0000, out_idx, last_q, ack_q, data_q};
    end

endmodule

// File: tb/tb_status_readback.sv
// -----------------------------------------------------------------------------
// tb_status_readback
//
// Self-checking bench for status_readback. A behavioural model holds the
// current snapshot as a queue of bytes (MS first); each accepted read pops one
// byte and an empty queue means the next read takes a fresh snapshot. The
// model is advanced on every rising edge and gpio_out is compared to it every
// cycle. Directed scenarios add literal expectations, then a randomized phase
// exercises strobe, rewind, address and reset interleavings.
// Inputs change on the falling edge; outputs are sampled after the rising edge.
// -----------------------------------------------------------------------------
module tb_status_readback;

`ifdef STATUS_READBACK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int          N    = 4;
    localparam logic [15:0] ADDR = 16'h0010;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic [31:0] gpio_in = '0;
    logic [31:0] reg_in  = '0;
    logic [31:0] gpio_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    status_readback #(
        .word_width (8),
        .num_words  (N),
        .addr_width (16),
        .my_addr    (ADDR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gpio_in  (gpio_in),
        .reg_in   (reg_in),
        .gpio_out (gpio_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    byte unsigned m_q[$];      // bytes of the current snapshot not yet read
    bit           m_busy;      // a read has been acknowledged, awaiting release
    logic [31:0]  m_out;
    bit           h_r[2];      // strobe history, models synchronizer delay
    bit           h_w[2];

    task automatic model_reset();
        m_q.delete();
        m_busy = 1'b0;
        m_out  = '0;
        h_r    = '{1'b0, 1'b0};
        h_w    = '{1'b0, 1'b0};
    endtask

    task automatic model_step();
        bit r_eff;
        bit w_eff;
        bit m;
        r_eff  = (LAT == 1) ? gpio_in[25] : h_r[1];
        w_eff  = (LAT == 1) ? gpio_in[26] : h_w[1];
        h_r[1] = h_r[0];
        h_r[0] = gpio_in[25];
        h_w[1] = h_w[0];
        h_w[0] = gpio_in[26];
        m      = (gpio_in[15:0] == ADDR);
        if (!m_busy) begin
            if (m && w_eff) begin
                m_q.delete();
            end else if (m && r_eff) begin
                if (m_q.size() == 0) begin
                    for (int k = N - 1; k >= 0; k--) m_q.push_back(reg_in[8*k +: 8]);
                end
                m_out[15:10] = 6'(N - m_q.size());
                m_out[7:0]   = m_q.pop_front();
                m_out[9]     = (m_q.size() == 0);
                m_out[8]     = 1'b1;
                m_busy       = 1'b1;
            end
        end else if (!r_eff) begin
            m_out[8] = 1'b0;
            m_busy   = 1'b0;
        end
    endtask

    // Compare process: every cycle, model vs DUT.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) model_reset();
            else model_step();
            #2;
            check("gpio_out_vs_model", gpio_out, m_out);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_bits(input logic [15:0] addr, input bit r, input bit w);
        gpio_in = {5'b0, w, r, 1'b0, 8'h00, addr};
    endtask

    // Counts rising edges until ack reaches level; gives up after 20.
    task automatic wait_ack(input bit level, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (gpio_out[8] !== level && n < 20);
    endtask

    task automatic start_read(input string tag, input logic [7:0] exp_data,
                              input int exp_idx, input bit exp_last);
        int n;
        @(negedge clk);
        set_bits(ADDR, 1'b1, 1'b0);
        wait_ack(1'b1, n);
        check({tag, "_rise_lat"}, n, LAT);
        check({tag, "_data"}, gpio_out[7:0], exp_data);
        check({tag, "_idx"}, gpio_out[15:10], exp_idx);
        check({tag, "_last"}, gpio_out[9], exp_last);
    endtask

    task automatic finish_read(input string tag, input logic [7:0] exp_data);
        int n;
        @(negedge clk);
        set_bits(ADDR, 1'b0, 1'b0);
        wait_ack(1'b0, n);
        check({tag, "_fall_lat"}, n, LAT);
        check({tag, "_hold"}, gpio_out[7:0], exp_data);
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp_data,
                             input int exp_idx, input bit exp_last);
        start_read(tag, exp_data, exp_idx, exp_last);
        finish_read(tag, exp_data);
    endtask

    task automatic rewind_pulse();
        @(negedge clk);
        set_bits(ADDR, 1'b0, 1'b1);
        @(negedge clk);
        set_bits(ADDR, 1'b0, 1'b0);
        repeat (LAT) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios, then randomized traffic
    // ------------------------------------------------------------------
    initial begin
        bit          r;
        bit          w;
        logic [15:0] a;

        set_bits(ADDR, 1'b0, 1'b0);
        reg_in = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        check("reset_gpio_out", gpio_out, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Four bytes, MS first, last only on the final byte.
        read_byte("s1_b0", 8'hDE, 0, 1'b0);
        read_byte("s1_b1", 8'hAD, 1, 1'b0);
        read_byte("s1_b2", 8'hBE, 2, 1'b0);
        read_byte("s1_b3", 8'hEF, 3, 1'b1);

        // Snapshot coherence and wrap to a fresh snapshot.
        read_byte("s2_b0", 8'hDE, 0, 1'b0);
        reg_in = 32'h12345678;
        read_byte("s2_b1", 8'hAD, 1, 1'b0);
        read_byte("s2_b2", 8'hBE, 2, 1'b0);
        read_byte("s2_b3", 8'hEF, 3, 1'b1);
        read_byte("s2_wrap", 8'h12, 0, 1'b0);

        // Address filter: strobe at a foreign address is ignored.
        @(negedge clk);
        set_bits(16'h0011, 1'b1, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("filter_no_ack", gpio_out[8], 1'b0);
        end
        check("filter_idx_held", gpio_out[15:10], 6'd0);
        @(negedge clk);
        set_bits(ADDR, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("filter_match_ack", gpio_out[8], 1'b1);
        check("filter_match_data", gpio_out[7:0], 8'h34);
        check("filter_match_idx", gpio_out[15:10], 6'd1);
        finish_read("filter", 8'h34);

        // Rewind in IDLE restarts at the MS byte with a fresh snapshot.
        reg_in = 32'hDEADBEEF;
        rewind_pulse();
        read_byte("rw_b0", 8'hDE, 0, 1'b0);
        read_byte("rw_b1", 8'hAD, 1, 1'b0);
        rewind_pulse();
        read_byte("rw_again", 8'hDE, 0, 1'b0);

        // Rewind and strobe together: no ack that edge, ack the next with DE.
        @(negedge clk);
        set_bits(ADDR, 1'b1, 1'b1);
        for (int e = 1; e <= LAT; e++) begin
            @(posedge clk);
            #1;
            check("both_no_ack", gpio_out[8], 1'b0);
            if (e == 1) begin
                @(negedge clk);
                set_bits(ADDR, 1'b1, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        check("both_ack", gpio_out[8], 1'b1);
        check("both_data", gpio_out[7:0], 8'hDE);
        check("both_idx", gpio_out[15:10], 6'd0);
        finish_read("both", 8'hDE);

        // Reset while ack is high after BE.
        read_byte("rst_b1", 8'hAD, 1, 1'b0);
        start_read("rst_b2", 8'hBE, 2, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_gpio_out", gpio_out, 32'h0);
        @(negedge clk);
        set_bits(ADDR, 1'b0, 1'b0);
        reg_in = 32'hCAFEF00D;
        @(negedge clk);
        rst = 1'b1;
        read_byte("rst_after", 8'hCA, 0, 1'b0);
        read_byte("rst_after1", 8'hFE, 1, 1'b0);

        // Randomized traffic, checked only by the per-cycle model compare.
        r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 30) r = ~r;
            w = ($urandom_range(0, 99) < 6);
            a = ($urandom_range(0, 99) < 85) ? ADDR : 16'($urandom);
            if ($urandom_range(0, 99) < 10) reg_in = $urandom;
            set_bits(a, r, w);
            if (i == 200) begin
                rst = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        set_bits(ADDR, 1'b0, 1'b0);
        repeat (LAT + 3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
